// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with LAT-cycle load/store response handshake.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LAT       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        resp_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [1:0]  CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        ready_q;
  logic        resp_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Request attributes captured at acceptance and held until the response.
  logic        we_q;
  logic        fault_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] rword_q;

  logic          accept;
  logic [31:0]   offset;
  logic [31:0]   word_idx;
  logic          in_range;
  logic          fault_d;
  logic [1:0]    lane_d;
  logic [3:0]    be_d;
  logic [31:0]   wrep_d;
  logic [31:0]   rword;
  logic [AW-1:0] mem_idx;
  logic [31:0]   acc_rdata_d;
  logic [31:0]   pend_rdata_d;

  logic [31:0] mem_q [DEPTH];

  // Shift the addressed lane down, keep the access width, then zero- or sign-extend.
  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [1:0]  size,
                                           input logic        uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_fmt = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: load_fmt = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_fmt = sh;
    endcase
  endfunction

  assign accept = req_i && ready_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    offset   = addr_i - BASE_ADDR;
    word_idx = {2'b00, offset[31:2]};
    in_range = word_idx < DEPTH;
    mem_idx  = word_idx[AW-1:0];
    lane_d   = offset[1:0];
    fault_d  = !in_range || (size_i == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size_i == SZ_HALF && offset[0]) || (size_i == SZ_WORD && offset[1:0] != 2'b00))
      fault_d = 1'b1;
`else
    if (size_i == SZ_HALF) lane_d = {offset[1], 1'b0};
    if (size_i == SZ_WORD) lane_d = 2'b00;
`endif
    case (size_i)
      SZ_BYTE: begin
        be_d   = 4'b0001 << lane_d;
        wrep_d = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_d   = 4'b0011 << lane_d;
        wrep_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d   = 4'b1111;
        wrep_d = wdata_i;
      end
    endcase
    rword        = mem_q[mem_idx];
    acc_rdata_d  = (we_i || fault_d) ? 32'h0 : load_fmt(rword, lane_d, size_i, uns_i);
    pend_rdata_d = (we_q || fault_q) ? 32'h0 : load_fmt(rword_q, lane_q, size_q, uns_q);
  end

  // NOTE: the storage array has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept && we_i && !fault_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[mem_idx][8*b +: 8] <= wrep_d[8*b +: 8];
      end
    end
  end

  // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      rword_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= we_i;
            fault_q <= fault_d;
            size_q  <= size_i;
            uns_q   <= uns_i;
            lane_q  <= lane_d;
            rword_q <= rword;
            ready_q <= 1'b0;
            if (LAT > 1) begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= acc_rdata_d;
              err_q   <= fault_d;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            rdata_q <= pend_rdata_d;
            err_q   <= fault_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a LAT=1/BASE=0 instance and a LAT=3/BASE=0x1000 instance,
// directed cases plus random traffic checked against a byte-level memory model.
module tb_data_mem_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        resp  [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] mref [2][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .uns_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
    .resp_o(resp[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_1000), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .uns_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
    .resp_o(resp[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h1000;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_fault(input int d, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] idx;
    idx = (a - base_of(d)) / 4;
    if (idx >= DEPTH) return 1'b1;
    if (sz == 2'd3) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_off(input logic [31:0] a, input logic [1:0] sz);
    int off;
    off = int'(a % 4);
`ifndef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'd1) off = off - (off % 2);
    if (sz == 2'd2) off = 0;
`endif
    return off;
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u);
    int nb, off, idx;
    logic [63:0] v;
    nb  = nbytes(sz);
    off = m_off(a, sz);
    idx = int'((a - base_of(d)) / 4);
    v   = 64'(mref[d][idx]) >> (8 * off);
    v   = v % (64'd1 << (8 * nb));
    if (!u && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  task automatic m_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd);
    int nb, off, idx;
    logic [31:0] w;
    nb  = nbytes(sz);
    off = m_off(a, sz);
    idx = int'((a - base_of(d)) / 4);
    w   = mref[d][idx];
    for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
    mref[d][idx] = w;
  endtask

  task automatic xact(input int d, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int lat;
    bit got;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wdata[d] = wd;
    check("ready_idle", 32'(ready[d]), 32'd1);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      req[d] = 1'b0;
      lat++;
      if (resp[d]) got = 1'b1;
      else begin
        check("busy_ready_low", 32'(ready[d]), 32'd0);
        check("busy_rdata_zero", rdata[d], 32'd0);
        check("busy_err_zero", 32'(err[d]), 32'd0);
      end
    end
    check("resp_latency", 32'(lat), 32'(lat_of(d)));
    rd = rdata[d];
    er = err[d];
  endtask

  task automatic run(input int d, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    bit f;
    logic [31:0] exp_rd;
    f = m_fault(d, a, sz);
    exp_rd = (w || f) ? 32'h0 : m_load(d, a, sz, u);
    xact(d, w, sz, u, a, wd, rd, er);
    check("model_rdata", rd, exp_rd);
    check("model_err", 32'(er), 32'(f));
    if (w && !f) m_store(d, a, sz, wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ready"}, 32'(ready[d]), 32'd1);
      check({tag, "_resp"}, 32'(resp[d]), 32'd0);
      check({tag, "_rdata"}, rdata[d], 32'd0);
      check({tag, "_err"}, 32'(err[d]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, prior;
    logic er;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0; uns[d] = 1'b0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word of the LAT=1 instance and eight words of the LAT=3 instance.
    for (int i = 0; i < DEPTH; i++) run(0, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, rd, er);
    for (int i = 0; i < 8; i++) run(1, 1'b1, 2'd2, 1'b0, 32'h1000 + 32'(4 * i), $urandom, rd, er);

    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
    check("st_word_err", 32'(er), 32'd0);
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    check("ld_word_deadbeef", rd, 32'hDEAD_BEEF);
    check("ld_word_err", 32'(er), 32'd0);

    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    run(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, rd, er);
    run(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
    check("ld_byte_signed", rd, 32'hFFFF_FF80);
    run(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
    check("ld_byte_unsigned", rd, 32'h0000_0080);
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    check("ld_word_after_byte", rd, 32'h8000_0000);

    run(0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd, er);
    check("oor_ld_rdata", rd, 32'h0);
    check("oor_ld_err", 32'(er), 32'd1);
    run(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, prior, er);
    run(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h5A5A_A5A5, rd, er);
    check("oor_st_err", 32'(er), 32'd1);
    run(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
    check("oor_st_word0_kept", rd, prior);

    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_8765, rd, er);
    run(0, 1'b0, 2'd1, 1'b1, 32'h11, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("half_mis_u_rdata", rd, 32'h0);
    check("half_mis_u_err", 32'(er), 32'd1);
`else
    check("half_mis_u_rdata", rd, 32'h0000_8765);
    check("half_mis_u_err", 32'(er), 32'd0);
`endif
    run(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("half_mis_s_rdata", rd, 32'h0);
`else
    check("half_mis_s_rdata", rd, 32'hFFFF_8765);
`endif

    run(0, 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, rd, er);
    check("rsvd_size_err", 32'(er), 32'd1);
    run(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, rd, er);
    check("rsvd_size_ld_rdata", rd, 32'h0);

    run(1, 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0, rd, er);
    check("below_base_err", 32'(er), 32'd1);
    run(1, 1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, rd, er);

    // Continuous request on the LAT=3 instance: one accept every LAT+1 cycles.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h1004;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check("hold_ready", 32'(ready[1]), 32'((c % 4) == 0));
      check("hold_resp", 32'(resp[1]), 32'((c % 4) == 3));
      if ((c % 4) == 3) check("hold_rdata", rdata[1], mref[1][1]);
    end
    req[1] = 1'b0;

    // Store accepted, then reset during WAIT: no response, store still committed.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h1008; wdata[1] = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    check("wait_ready_low", 32'(ready[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midwait_reset");
    m_store(1, 32'h1008, 2'd2, 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_reset_no_resp", 32'(resp[1]), 32'd0);
      check("post_reset_ready", 32'(ready[1]), 32'd1);
    end
    run(1, 1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, rd, er);
    check("store_survives_reset", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if (($urandom % 8) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH * 4 + 15));
      run(0, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, er);
    end
    for (int i = 0; i < 40; i++) begin
      run(1, 1'($urandom), 2'($urandom), 1'($urandom),
          32'h1000 + 32'($urandom_range(0, 31)), $urandom, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words; SHALL be a power of two, 4..65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be 4-byte aligned.
REQ-003 Parameter LAT, default 1, read latency in cycles from acceptance to response; legal range 1..4.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  1  request strobe; accepted when req_i && ready_o at a rising edge.
REQ-007 we_i  input  1  1 = store, 0 = load.
REQ-008 size_i  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-009 uns_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 addr_i  input  32  byte address.
REQ-011 wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready_o  output  1  controller can accept a request this cycle.
REQ-013 resp_o  output  1  one-cycle pulse marking completion of the accepted request.
REQ-014 rdata_o  output  32  load result, valid while resp_o=1, else 0.
REQ-015 err_o  output  1  request faulted, valid while resp_o=1, else 0.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; reset state IDLE; ready_o=1 only in IDLE.
REQ-017 IDLE: on acceptance, latch we, size, uns, address and fault flags; go to WAIT if LAT>1, else RESP.
REQ-018 WAIT: count down LAT-1 cycles, then RESP; req_i ignored.
REQ-019 RESP: resp_o=1 for exactly one cycle, then IDLE; a new request is never accepted in the RESP cycle.
REQ-020 Word index = (addr_i - BASE_ADDR) >> 2, computed modulo 2^32; in range iff index < DEPTH.
REQ-021 Store: memory updated in the acceptance cycle using byte enables (byte: 1 lane by addr[1:0]; half: 2 lanes by addr[1]; word: all 4), with data replicated to the selected lanes.
REQ-022 Load: word read at acceptance; result shifted right by the lane offset, masked to the size, extended per uns_i; held until RESP.
REQ-023 Out-of-range access: store has no effect, load returns 0, err_o=1.
REQ-024 size_i=11: treated as a fault: no write, rdata_o=0, err_o=1.
REQ-025 Store responses: rdata_o=0; err_o per fault rules.
REQ-026 A store followed by a load to the same address SHALL return the stored data.

Reset
REQ-027 rst_n low forces IDLE, ready_o=1, resp_o=0, rdata_o=0, err_o=0, and clears the latency counter, immediately and asynchronously.
REQ-028 Reset mid-WAIT or mid-RESP abandons the pending response (no resp_o pulse after release); memory contents are not cleared and any store already accepted stays committed.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: half at odd address or word with addr[1:0]!=0 is a fault (no write, rdata_o=0, err_o=1).
REQ-030 Macro undefined: misaligned accesses are forced aligned (half clears addr[0], word clears addr[1:0]) and are not faults.

Verification
REQ-031 LAT=1: store word 32'hDEAD_BEEF @0x10, then load word @0x10 -> resp_o one cycle after each acceptance, rdata_o=32'hDEAD_BEEF, err_o=0.
REQ-032 Store byte 8'h80 @0x13 over 0, load byte signed @0x13 -> 32'hFFFF_FF80; load byte unsigned -> 32'h0000_0080; load word @0x10 -> 32'h8000_0000.
REQ-033 LAT=3: hold req_i high continuously -> accept, ready_o low 3 cycles, resp_o on cycle 3, next accept on cycle 4.
REQ-034 DEPTH=256: load word @0x400 -> rdata_o=0, err_o=1; store @0x400 leaves word 0 unchanged.
REQ-035 Half load @0x11: with DMEM_MISALIGN_TRAP_EN -> err_o=1, rdata_o=0; without -> data from @0x10, err_o=0.
REQ-036 Assert rst_n low during WAIT (LAT=3) -> outputs zero immediately, no resp_o after release, ready_o=1.
